// File: rtl/ili9341_init_ctrl.sv
// ILI9341 init sequencer: pulses the panel reset, walks a fixed command/data/delay table,
// then owns the SPI byte channel for RGB565 pixel streaming (high byte first).
module ili9341_init_ctrl #(
    parameter int unsigned RST_LOW_CYCLES  = 1000,
    parameter int unsigned RST_WAIT_CYCLES = 120000,
    parameter int unsigned DELAY_UNIT      = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    output logic        lcd_reset,
    output logic        init_done,
    output logic        busy,
    input  logic        px_valid,
    input  logic [15:0] px_data,
    output logic        px_ready
);

    localparam int unsigned DLY_MAX = 32'd255 * DELAY_UNIT;
    localparam int unsigned RST_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES
                                                                        : RST_WAIT_CYCLES;
    localparam int unsigned CNT_MAX = (RST_MAX > DLY_MAX) ? RST_MAX : DLY_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = 5;

    localparam logic [1:0] K_CMD = 2'b00;
    localparam logic [1:0] K_DAT = 2'b01;
    localparam logic [1:0] K_DLY = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        FETCH,
        SEND,
        DELAY,
        READY,
        PX_HI,
        PX_LO
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [7:0]         px_lo, px_lo_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_dc_nxt;
    logic               tx_valid_nxt;
    logic               lcd_reset_nxt;
    logic               init_done_nxt;
    logic               busy_nxt;
    logic               px_ready_nxt;
    logic               start_s, start_q;
    logic               start_rise_c;
    logic [9:0]         ent_c;

    // Init table entry: {kind, payload}; delay payloads are in DELAY_UNIT counts
    function automatic logic [9:0] tbl(input logic [IDX_W-1:0] i);
        case (i)
            5'd0:    tbl = {K_CMD, 8'h01};
            5'd1:    tbl = {K_DLY, 8'd5};
            5'd2:    tbl = {K_CMD, 8'h11};
            5'd3:    tbl = {K_DLY, 8'd120};
            5'd4:    tbl = {K_CMD, 8'h3A};
            5'd5:    tbl = {K_DAT, 8'h55};
            5'd6:    tbl = {K_CMD, 8'h36};
            5'd7:    tbl = {K_DAT, 8'h48};
            5'd8:    tbl = {K_CMD, 8'h29};
            5'd9:    tbl = {K_CMD, 8'h2A};
            5'd10:   tbl = {K_DAT, 8'h00};
            5'd11:   tbl = {K_DAT, 8'h00};
            5'd12:   tbl = {K_DAT, 8'h00};
            5'd13:   tbl = {K_DAT, 8'hEF};
            5'd14:   tbl = {K_CMD, 8'h2B};
            5'd15:   tbl = {K_DAT, 8'h00};
            5'd16:   tbl = {K_DAT, 8'h00};
            5'd17:   tbl = {K_DAT, 8'h01};
            5'd18:   tbl = {K_DAT, 8'h3F};
            5'd19:   tbl = {K_CMD, 8'h2C};
            default: tbl = {2'b11, 8'h00};
        endcase
    endfunction

    assign ent_c        = tbl(idx);
    assign start_rise_c = start_s && !start_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        logic lo_gap;
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        px_lo_nxt   = px_lo;
        tx_data_nxt = tx_data;
        tx_dc_nxt   = tx_dc;
        lo_gap      = 1'b0;

        case (state)
            IDLE: begin
                if (start_rise_c) begin
                    state_nxt = RST_LOW;
                    idx_nxt   = '0;
                    cnt_nxt   = CNT_W'(RST_LOW_CYCLES - 32'd1);
                end
            end
            RST_LOW: begin
                if (cnt == '0) begin
                    state_nxt = RST_WAIT;
                    cnt_nxt   = CNT_W'(RST_WAIT_CYCLES - 32'd1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = FETCH;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            FETCH: begin
                case (ent_c[9:8])
                    K_CMD, K_DAT: begin
                        state_nxt   = SEND;
                        tx_data_nxt = ent_c[7:0];
                        tx_dc_nxt   = ent_c[8];
                    end
                    K_DLY: begin
                        // A zero-length delay just advances to the next entry
                        if (ent_c[7:0] == 8'd0) begin
                            idx_nxt = idx + IDX_W'(1);
                        end else begin
                            state_nxt = DELAY;
                            cnt_nxt   = CNT_W'(32'(ent_c[7:0]) * DELAY_UNIT - 32'd1);
                        end
                    end
                    default: state_nxt = READY;
                endcase
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = FETCH;
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = FETCH;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            READY: begin
                if (start_rise_c) begin
                    state_nxt = RST_LOW;
                    idx_nxt   = '0;
                    cnt_nxt   = CNT_W'(RST_LOW_CYCLES - 32'd1);
                end else if (px_valid && px_ready) begin
                    state_nxt   = PX_HI;
                    px_lo_nxt   = px_data[7:0];
                    tx_data_nxt = px_data[15:8];
                    tx_dc_nxt   = 1'b1;
                end
            end
            PX_HI: begin
                // One idle cycle separates the two pixel bytes, like FETCH does in the table walk
                if (tx_valid && tx_ready) begin
                    state_nxt   = PX_LO;
                    lo_gap      = 1'b1;
                    tx_data_nxt = px_lo;
                end
            end
            PX_LO: begin
                if (tx_valid && tx_ready) begin
                    state_nxt = READY;
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_valid_nxt  = (state_nxt == SEND) || (state_nxt == PX_HI) ||
                        ((state_nxt == PX_LO) && !lo_gap);
        lcd_reset_nxt = (state_nxt != RST_LOW);
        init_done_nxt = (state_nxt == READY) || (state_nxt == PX_HI) || (state_nxt == PX_LO);
        px_ready_nxt  = (state_nxt == READY);
        busy_nxt      = (state_nxt == RST_LOW) || (state_nxt == RST_WAIT) ||
                        (state_nxt == FETCH) || (state_nxt == SEND) || (state_nxt == DELAY);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            px_lo     <= 8'h00;
            start_s   <= 1'b0;
            start_q   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            tx_dc     <= 1'b0;
            lcd_reset <= 1'b1;
            init_done <= 1'b0;
            busy      <= 1'b0;
            px_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            px_lo     <= px_lo_nxt;
            start_s   <= start;
            start_q   <= start_s;
            tx_valid  <= tx_valid_nxt;
            tx_data   <= tx_data_nxt;
            tx_dc     <= tx_dc_nxt;
            lcd_reset <= lcd_reset_nxt;
            init_done <= init_done_nxt;
            busy      <= busy_nxt;
            px_ready  <= px_ready_nxt;
        end
    end

endmodule

// File: tb/tb_ili9341_init_ctrl.sv
// Scoreboard bench for ili9341_init_ctrl: expected bytes are queued by the stimulus,
// a negedge monitor pops and compares on every tx handshake.
`timescale 1ns/1ps
module tb_ili9341_init_ctrl;

    localparam int unsigned RLC = 4;
    localparam int unsigned RWC = 6;
    localparam int unsigned DU  = 3;
    localparam logic [13:0] RESET_VEC = {1'b1, 13'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic        px_valid = 1'b0;
    logic [15:0] px_data = 16'h0000;
    logic        tx_valid, tx_dc, lcd_reset, init_done, busy, px_ready;
    logic [7:0]  tx_data;
    logic [13:0] outs;

    assign outs = {lcd_reset, tx_valid, tx_data, tx_dc, init_done, busy, px_ready};

    always #5 clk = ~clk;

    ili9341_init_ctrl #(
        .RST_LOW_CYCLES (RLC),
        .RST_WAIT_CYCLES(RWC),
        .DELAY_UNIT     (DU)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_dc    (tx_dc),
        .lcd_reset(lcd_reset),
        .init_done(init_done),
        .busy     (busy),
        .px_valid (px_valid),
        .px_data  (px_data),
        .px_ready (px_ready)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } exp_t;

    exp_t       exp_q[$];
    int         hs_cyc_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         hs_count = 0;
    int         cmd_count = 0;
    int         valid_cycles = 0;
    int         stall_cycles = 0;
    int         lcd_pulses = 0;
    int         lcd_low_run = 0;
    int         px_low = 0;
    logic       px_active = 1'b0;
    logic       prev_lcd = 1'b1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_dc = 1'b0;

    logic [7:0] init_bytes [18] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29, 8'h2A, 8'h00,
                                    8'h00, 8'h00, 8'hEF, 8'h2B, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2C};
    logic       init_dc [18]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void fail_wait(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endfunction

    // Monitor: handshakes, hold stability, lcd_reset pulse width, px_ready low time
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tx_valid) valid_cycles++;
        if (rst && prev_hold)
            check("hold_stable", {22'd0, tx_valid, tx_data, tx_dc}, {22'd0, 1'b1, prev_data, prev_dc});
        if (tx_valid && !tx_ready) stall_cycles++;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        prev_dc   = tx_dc;
        if (tx_valid && tx_ready) begin
            hs_count++;
            hs_cyc_q.push_back(cyc);
            if (!tx_dc) cmd_count++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_byte: got 0x%0h dc=%0b with nothing queued", tx_data, tx_dc);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("tx_dc", 32'(tx_dc), 32'(e.dc));
            end
        end
        if (!lcd_reset) begin
            lcd_low_run++;
        end else if (!prev_lcd) begin
            lcd_pulses++;
            check("lcd_reset_low_cycles", lcd_low_run, RLC);
            lcd_low_run = 0;
        end
        prev_lcd = lcd_reset;
        if (px_active && px_ready) begin
            check("px_ready_low_cycles", px_low, 3);
            px_active = 1'b0;
        end else if (px_active) begin
            px_low++;
        end
        if (px_valid && px_ready) begin
            px_active = 1'b1;
            px_low    = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    task automatic push_init();
        for (int i = 0; i < 18; i++) exp_q.push_back('{init_bytes[i], init_dc[i]});
    endtask

    task automatic wait_hs(input int n, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (hs_count >= n) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_wait("wait_handshakes");
    endtask

    task automatic wait_init_done(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (init_done) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_wait("wait_init_done");
    endtask

    task automatic wait_tx_valid(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (tx_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_wait("wait_tx_valid");
    endtask

    task automatic send_pixel(input logic [15:0] p);
        bit ok = 1'b0;
        px_valid = 1'b1;
        px_data  = p;
        for (int i = 0; i < 50; i++) begin
            if (px_ready) begin tick(); ok = 1'b1; break; end
            tick();
        end
        px_valid = 1'b0;
        if (!ok) fail_wait("px_accept");
    endtask

    initial begin
        int h0, c0, gi, v0, l0, s0;

        // Reset default and idle without start
        tick();
        tick();
        check("reset_outputs", 32'(outs), 32'(RESET_VEC));
        rst = 1'b1;
        v0  = valid_cycles;
        repeat (50) tick();
        check("idle_no_tx_valid", valid_cycles - v0, 0);
        check("idle_outputs", 32'(outs), 32'(RESET_VEC));

        // Full init, with a start edge during the long delay that must be ignored
        tx_ready = 1'b1;
        h0 = hs_count;
        c0 = cmd_count;
        gi = hs_cyc_q.size();
        push_init();
        pulse_start();
        wait_hs(h0 + 2, 2000);
        pulse_start();
        check("busy_mid_table", 32'({busy, init_done}), 32'b10);
        wait_init_done(3000);
        check("init1_queue_drained", exp_q.size(), 0);
        check("init1_handshakes", hs_count - h0, 18);
        check("init1_commands", cmd_count - c0, 8);
        check("init1_ready_flags", 32'({init_done, px_ready, busy, lcd_reset}), 32'b1101);
        if (hs_cyc_q.size() >= gi + 4) begin
            // handshake spacing: 2 cycles back-to-back, plus n*DU + 1 across a delay entry
            check("gap_01_11", hs_cyc_q[gi+1] - hs_cyc_q[gi], 2 + 5 * DU + 1);
            check("gap_11_3A", hs_cyc_q[gi+2] - hs_cyc_q[gi+1], 2 + 120 * DU + 1);
            check("gap_3A_55", hs_cyc_q[gi+3] - hs_cyc_q[gi+2], 2);
        end else begin
            fail_wait("handshake_times");
        end
        check("lcd_pulses_init1", lcd_pulses, 1);

        // Pixel streaming
        exp_q.push_back('{8'hF8, 1'b1});
        exp_q.push_back('{8'h00, 1'b1});
        exp_q.push_back('{8'h07, 1'b1});
        exp_q.push_back('{8'hE0, 1'b1});
        h0 = hs_count;
        send_pixel(16'hF800);
        send_pixel(16'h07E0);
        wait_hs(h0 + 4, 50);
        repeat (3) tick();
        check("px_queue_drained", exp_q.size(), 0);
        check("px_init_done_held", 32'({init_done, px_ready}), 32'b11);

        // Re-init from READY with backpressure on 0x3A
        h0 = hs_count;
        l0 = lcd_pulses;
        push_init();
        pulse_start();
        check("reinit_flags", 32'({init_done, lcd_reset, busy}), 32'b001);
        wait_hs(h0 + 2, 2000);
        tx_ready = 1'b0;
        wait_tx_valid(1000);
        check("stall_byte", 32'({tx_data, tx_dc}), 32'({8'h3A, 1'b0}));
        s0 = stall_cycles;
        repeat (7) tick();
        tx_ready = 1'b1;
        wait_init_done(3000);
        check("stall_cycles", stall_cycles - s0, 7);
        check("init2_queue_drained", exp_q.size(), 0);
        check("init2_handshakes", hs_count - h0, 18);
        check("init2_lcd_pulse", lcd_pulses - l0, 1);

        // Async reset while a byte is held
        tx_ready = 1'b0;
        pulse_start();
        wait_tx_valid(200);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs), 32'(RESET_VEC));
        tick();
        tick();
        rst      = 1'b1;
        tx_ready = 1'b1;
        v0       = valid_cycles;
        repeat (30) tick();
        check("post_reset_no_tx_valid", valid_cycles - v0, 0);
        check("post_reset_idle", 32'(outs), 32'(RESET_VEC));

        // Recovery init after reset
        h0 = hs_count;
        push_init();
        pulse_start();
        wait_init_done(3000);
        check("init3_queue_drained", exp_q.size(), 0);
        check("init3_handshakes", hs_count - h0, 18);
        check("lcd_pulses_total", lcd_pulses, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (%0d/%0d so far)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ili9341_init_ctrl.md
# ili9341_init_ctrl

Command sequencer between the board-level init button and the SPI byte master of the ILI9341 path. On a start request it pulses the panel hardware reset and walks a fixed internal init table of command, data and delay entries, handing bytes to the SPI byte master. The table ends with a full-screen window and RAMWR. The block then becomes the single owner of the SPI byte channel for pixel streaming, splitting 16-bit RGB565 pixels into two data bytes.

## Interface
Parameters:
- RST_LOW_CYCLES, 1000: cycles lcd_reset is held low.
- RST_WAIT_CYCLES, 120000: cycles after lcd_reset release before the first table entry.
- DELAY_UNIT, 100000: cycles per delay-entry count (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  init request level (init button); rising edge acts.
- tx_ready  in  1  SPI byte master can accept a byte.
- tx_valid  out  1  byte offered to the SPI byte master.
- tx_data  out  8  byte to send.
- tx_dc  out  1  0 = command, 1 = data.
- lcd_reset  out  1  panel reset, active-low.
- init_done  out  1  table finished; pixel streaming enabled.
- busy  out  1  reset pulse or table walk in progress.
- px_valid  in  1  pixel offered.
- px_data  in  16  RGB565 pixel.
- px_ready  out  1  pixel accepted when px_valid && px_ready.

## Operation
- Entry format is {kind[1:0], payload[7:0]}. kind 00 is a command byte (dc=0), 01 is a data byte (dc=1), 10 is a delay of payload×DELAY_UNIT cycles, and 11 is END.
- The table has 21 entries, idx 0..20: C01, W5, C11, W120, C3A, D55, C36, D48, C29, C2A, D00, D00, D00, DEF, C2B, D00, D00, D01, D3F, C2C, END. This gives 18 bytes: 8 commands and 10 data.
- States: IDLE, RST_LOW, RST_WAIT, FETCH, SEND, DELAY, READY, PX_HI, PX_LO.
- IDLE to RST_LOW on a start rising edge (start && !start_q, with start_q registered). idx is cleared.
- RST_LOW: lcd_reset=0 for RST_LOW_CYCLES, then RST_WAIT.
- RST_WAIT: lcd_reset=1 for RST_WAIT_CYCLES, then FETCH.
- FETCH decodes table[idx] and dispatches by kind:
  - command/data: go to SEND.
  - delay: go to DELAY. Payload 0 means FETCH of idx+1 on the next cycle.
  - END: go to READY.
- SEND: tx_valid=1 with tx_data/tx_dc held. When tx_valid && tx_ready, idx++ and go to FETCH.
- DELAY: count payload×DELAY_UNIT cycles, then idx++ and go to FETCH.
- READY: init_done=1 and px_ready=1. When px_valid && px_ready, latch px_data and go to PX_HI.
- PX_HI sends px[15:8] with dc=1. After its handshake, PX_LO sends px[7:0] with dc=1. Then back to READY.
- A start rising edge is ignored in RST_LOW through DELAY, PX_HI and PX_LO.
- A start rising edge in READY clears init_done and restarts from RST_LOW.
- busy=1 in RST_LOW, RST_WAIT, FETCH, SEND and DELAY.
- Counters are wide enough for the largest parameter product (255×DELAY_UNIT); no wrap.

## Timing
- Reset values: lcd_reset=1, tx_valid=0, tx_data=0x00, tx_dc=0, init_done=0, busy=0, px_ready=0, state=IDLE, idx=0.
- Asserting rst in any state forces reset values immediately, including mid-handshake. An outstanding tx_valid drops with no completion.
- Edge-to-reset latency: start high at edge N makes the edge detect true, so lcd_reset=0 from edge N+1. lcd_reset is low for exactly RST_LOW_CYCLES cycles.
- tx_valid rises one cycle after FETCH. tx_data and tx_dc must not change while tx_valid && !tx_ready. tx_valid drops the cycle after the handshake; the minimum gap between bytes is 1 cycle (FETCH).
- A delay entry of count n adds exactly n×DELAY_UNIT cycles plus 1 FETCH cycle.
- px_ready is low from the acceptance cycle until after the PX_LO handshake, so at most one pixel is in flight. The peak rate is one pixel per 4 cycles with tx_ready stuck at 1.
- init_done rises in the cycle READY is entered. It stays high until a re-init start or reset.

## Test plan
- Reset default: rst=0, then rst=1 with start=0 for 50 cycles. All outputs hold reset values and tx_valid never asserts.
- Full init, with RST_LOW_CYCLES=4, RST_WAIT_CYCLES=6, DELAY_UNIT=3, tx_ready=1:
  - Pulse start; lcd_reset is low for exactly 4 cycles.
  - Exactly 18 handshakes occur, in the order 01,11,3A,55,36,48,29,2A,00,00,00,EF,2B,00,00,01,3F,2C.
  - dc is 0 only on the 8 commands.
  - The gap between 0x01 and 0x11 is 15+1 cycles, and between 0x11 and 0x3A is 360+1 cycles.
  - init_done then goes to 1.
- Backpressure: drop tx_ready for 7 cycles during byte 0x3A. tx_valid stays 1 and tx_data/tx_dc stay 0x3A/0 stable; one transfer completes when tx_ready returns.
- Pixel stream after init_done: send pixels 0xF800 then 0x07E0 with tx_ready=1. Bytes are F8,00,07,E0 with dc=1, and px_ready is low for 3 cycles after each accept.
- Start ignored and re-init:
  - A start edge mid-table changes nothing; the byte order is still intact.
  - A start edge in READY drops init_done and gives a new lcd_reset low pulse, then all 18 bytes again.
- Async reset mid-SEND: assert rst while tx_valid=1. All outputs take reset values without a clock edge, and after release the block idles until a new start edge.
